// File: rtl/adc_scan_capture.sv
// Multi-channel ADC scan engine: drives convst/cs/rd handshake, scans NUM_CH channels per
// frame on a programmable frame timer and stores samples interleaved in a capture RAM.
module adc_scan_capture #(
    parameter int DATA_W      = 8,
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 3,
    parameter int ADDR_W      = 12,
    parameter int CONV_CYCLES = 2,
    parameter int RD_CYCLES   = 3,
    parameter int SAMPLE_DIV  = 1000,
    parameter int EOC_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     one_shot,
    output logic [CH_W-1:0]          chnl,
    output logic                     n_convst,
    input  logic                     n_eoc,
    output logic                     n_cs,
    output logic                     n_rd,
    input  logic [DATA_W-1:0]        adc_in,
    output logic [NUM_CH*DATA_W-1:0] latest,
    output logic                     frame_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    output logic                     timeout,
    output logic [ADDR_W-1:0]        wr_ptr,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data
);
    localparam int DEPTH  = 2**ADDR_W;
    localparam int CI_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PH_MAX = (CONV_CYCLES > RD_CYCLES) ? CONV_CYCLES : RD_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TO_W   = $clog2(EOC_TIMEOUT + 1);
    localparam int FT_W   = $clog2(SAMPLE_DIV);

    typedef enum logic [2:0] {IDLE, SETUP, CONV, WAIT_EOC, READ, WRITE, WAIT_TICK} state_t;
    state_t state_reg, state_next;

    logic              eoc_meta_reg, eoc_s_reg;
    logic [CI_W-1:0]   ch_reg;
    logic [PH_W-1:0]   ph_reg;
    logic [TO_W-1:0]   to_reg;
    logic [FT_W-1:0]   ft_reg;
    logic              one_shot_reg, busy_reg, done_reg, overrun_reg, timeout_reg, frame_valid_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [DATA_W-1:0] sample_reg, rd_data_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic start, abort, tick, last_ch, to_hit, wr_en, wrap, to_fire, ph_next_en;

    assign start   = (state_reg == IDLE) && arm && !stop;
    assign abort   = (state_reg != IDLE) && stop;
    assign tick    = busy_reg && (ft_reg == FT_W'(SAMPLE_DIV - 1));
    assign last_ch = (ch_reg == CI_W'(NUM_CH - 1));
    assign to_hit  = (to_reg == TO_W'(EOC_TIMEOUT - 1));
    assign wr_en   = (state_reg == WRITE) && !stop;
    assign wrap    = (wr_ptr_reg == '1);
    // Timeout fires only while still waiting on the expected eoc level.
    assign to_fire = !abort && to_hit &&
                     (((state_reg == SETUP) && !eoc_s_reg) || ((state_reg == WAIT_EOC) && eoc_s_reg));
    assign ph_next_en = (state_next == state_reg) && ((state_reg == CONV) || (state_reg == READ));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            eoc_meta_reg    <= 1'b1;
            eoc_s_reg       <= 1'b1;
            ch_reg          <= '0;
            ph_reg          <= '0;
            to_reg          <= '0;
            ft_reg          <= '0;
            one_shot_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
            timeout_reg     <= 1'b0;
            frame_valid_reg <= 1'b0;
            wr_ptr_reg      <= '0;
            sample_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            eoc_meta_reg    <= n_eoc;
            eoc_s_reg       <= eoc_meta_reg;
            ph_reg          <= ph_next_en ? ph_reg + PH_W'(1) : '0;
            to_reg          <= (state_next == state_reg) ? to_reg + TO_W'(1) : '0;
            frame_valid_reg <= wr_en && last_ch;
            if (start) begin
                ch_reg       <= '0;
                ft_reg       <= '0;
                one_shot_reg <= one_shot;
                busy_reg     <= 1'b1;
                done_reg     <= 1'b0;
                overrun_reg  <= 1'b0;
                timeout_reg  <= 1'b0;
                wr_ptr_reg   <= '0;
            end else begin
                if (busy_reg)
                    ft_reg <= tick ? '0 : ft_reg + FT_W'(1);
                if (busy_reg && state_next == IDLE)
                    busy_reg <= 1'b0;
                if (tick && state_reg != WAIT_TICK)
                    overrun_reg <= 1'b1;
                if (to_fire)
                    timeout_reg <= 1'b1;
                if (wr_en) begin
                    wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
                    ch_reg     <= last_ch ? '0 : ch_reg + CI_W'(1);
                    if (last_ch && one_shot_reg && wrap)
                        done_reg <= 1'b1;
                end
            end
            if (state_reg == READ && ph_reg == PH_W'(RD_CYCLES - 1))
                sample_reg <= adc_in;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:      if (start) state_next = SETUP;
                SETUP:     if (eoc_s_reg) state_next = CONV;
                           else if (to_hit) state_next = IDLE;
                CONV:      if (ph_reg == PH_W'(CONV_CYCLES - 1)) state_next = WAIT_EOC;
                WAIT_EOC:  if (!eoc_s_reg) state_next = READ;
                           else if (to_hit) state_next = IDLE;
                READ:      if (ph_reg == PH_W'(RD_CYCLES - 1)) state_next = WRITE;
                WRITE:     if (!last_ch) state_next = SETUP;
                           else if (one_shot_reg && wrap) state_next = IDLE;
                           else state_next = WAIT_TICK;
                WAIT_TICK: if (tick) state_next = SETUP;
                default:   state_next = IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset releases them at once.
    always_comb begin
        n_convst = 1'b1;
        n_cs     = 1'b1;
        n_rd     = 1'b1;
        case (state_reg)
            CONV: n_convst = 1'b0;
            READ: begin
                n_cs = 1'b0;
                n_rd = 1'b0;
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_latest
        logic [DATA_W-1:0] slot_reg;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                slot_reg <= '0;
            else if (wr_en && ch_reg == CI_W'(gi))
                slot_reg <= sample_reg;
        end
        assign latest[gi*DATA_W +: DATA_W] = slot_reg;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= sample_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_data_reg <= '0;
        else
            rd_data_reg <= mem[rd_addr];
    end

    assign chnl        = CH_W'(ch_reg);
    assign frame_valid = frame_valid_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign overrun     = overrun_reg;
    assign timeout     = timeout_reg;
    assign wr_ptr      = wr_ptr_reg;
    assign rd_data     = rd_data_reg;
endmodule

// File: tb/tb_adc_scan_capture.sv
// Directed bench for adc_scan_capture: one-shot, ring, overrun, timeout, stop and async reset.
module tb_adc_scan_capture;
    localparam int DATA_W = 8, NUM_CH = 4, CH_W = 3, ADDR_W = 4;
    localparam int CONV_CYCLES = 2, RD_CYCLES = 3, SAMPLE_DIV = 10, EOC_TIMEOUT = 255;

    logic clk = 1'b0;
    logic reset = 1'b1, arm = 1'b0, stop = 1'b0, one_shot = 1'b0;
    logic n_eoc = 1'b1;
    logic n_convst, n_cs, n_rd, frame_valid, busy, done, overrun, timeout;
    logic [CH_W-1:0] chnl;
    logic [DATA_W-1:0] adc_in = '0;
    logic [DATA_W-1:0] rd_data;
    logic [NUM_CH*DATA_W-1:0] latest;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_addr = '0;

    int checks = 0, failures = 0;
    int frame_idx = 0, frame_base = 0;
    bit adc_en = 1'b1;
    int conv_run = 0, rd_run = 0, cs_run = 0, conv_w = 0, rd_w = 0, cs_w = 0;

    adc_scan_capture #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .ADDR_W(ADDR_W),
        .CONV_CYCLES(CONV_CYCLES), .RD_CYCLES(RD_CYCLES),
        .SAMPLE_DIV(SAMPLE_DIV), .EOC_TIMEOUT(EOC_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .one_shot(one_shot),
        .chnl(chnl), .n_convst(n_convst), .n_eoc(n_eoc), .n_cs(n_cs), .n_rd(n_rd),
        .adc_in(adc_in), .latest(latest), .frame_valid(frame_valid), .busy(busy),
        .done(done), .overrun(overrun), .timeout(timeout), .wr_ptr(wr_ptr),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // ADC model: eoc falls two cycles after convst ends, rises when read starts.
    // Data returns 8'h10*frame + channel, frame counted from the last arm.
    bit pend = 1'b0;
    int dly = 0;
    always @(negedge clk) begin
        if (frame_valid) frame_idx = frame_idx + 1;
        adc_in = 8'(8'h10 * (frame_idx - frame_base) + int'(chnl));
        if (!adc_en) begin
            n_eoc = 1'b1;
            pend  = 1'b0;
        end else begin
            if (!n_convst) begin
                pend = 1'b1;
                dly  = 0;
            end else if (pend) begin
                dly++;
                if (dly == 2) begin
                    n_eoc = 1'b0;
                    pend  = 1'b0;
                end
            end
            if (!n_rd) n_eoc = 1'b1;
        end
    end

    // Strobe width monitor: records the length of the most recent low pulse.
    always @(negedge clk) begin
        if (!n_convst) conv_run++; else if (conv_run != 0) begin conv_w = conv_run; conv_run = 0; end
        if (!n_rd)     rd_run++;   else if (rd_run != 0)   begin rd_w = rd_run;     rd_run = 0;   end
        if (!n_cs)     cs_run++;   else if (cs_run != 0)   begin cs_w = cs_run;     cs_run = 0;   end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic do_arm(input logic os);
        frame_base = frame_idx;
        one_shot = os;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        $display("arm one_shot=%0d", os);
    endtask

    task automatic read_ram(input int a, output logic [DATA_W-1:0] d);
        rd_addr = ADDR_W'(a);
        @(negedge clk);
        d = rd_data;
    endtask

    initial begin
        int fv_n, k, reads;
        logic ovr_first, prev;
        logic [DATA_W-1:0] d;

        // Reset state, sampled while reset is held
        repeat (3) @(negedge clk);
        check("rst_chnl", chnl, 0);
        check("rst_strobes", {n_convst, n_cs, n_rd}, 3'b111);
        check("rst_latest", latest, 0);
        check("rst_flags", {frame_valid, busy, done, overrun, timeout}, 5'b0);
        check("rst_wr_ptr", wr_ptr, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        @(negedge clk);

        // One-shot fill: 4 frames of 4 channels fill the 16-word RAM
        do_arm(1'b1);
        fv_n = 0;
        ovr_first = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (frame_valid) begin
                fv_n++;
                if (fv_n == 1) ovr_first = overrun;
            end
        end
        check("os_done", done, 1);
        check("os_frames", fv_n, 4);
        check("os_busy", busy, 0);
        check("os_wr_ptr", wr_ptr, 0);
        check("os_overrun_first_frame", ovr_first, 1);
        check("os_latest", latest, 32'h33323130);
        check("conv_width", conv_w, CONV_CYCLES);
        check("rd_width", rd_w, RD_CYCLES);
        check("cs_width", cs_w, RD_CYCLES);
        for (int a = 0; a < 16; a++) begin
            read_ram(a, d);
            check($sformatf("os_ram[%0d]", a), d, 8'(8'h10 * (a / 4) + (a % 4)));
        end

        // Ring mode: 5 frames, frame 4 overwrites words 0..3
        do_arm(1'b0);
        fv_n = 0;
        for (int i = 0; i < 3000 && fv_n < 5; i++) begin
            @(negedge clk);
            if (frame_valid) fv_n++;
        end
        check("ring_frames", fv_n, 5);
        check("ring_busy", busy, 1);
        check("ring_wr_ptr", wr_ptr, 4);
        check("ring_latest", latest, 32'h43424140);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("ring_stop_busy", busy, 0);
        check("ring_stop_done", done, 0);
        for (int a = 0; a < 16; a++) begin
            read_ram(a, d);
            check($sformatf("ring_ram[%0d]", a), d,
                  (a < 4) ? 8'(8'h40 + a) : 8'(8'h10 * (a / 4) + (a % 4)));
        end

        // Stop during the second READ of a frame
        do_arm(1'b1);
        reads = 0;
        prev = 1'b1;
        for (int i = 0; i < 1000 && reads < 2; i++) begin
            @(negedge clk);
            if (!n_rd && prev) reads++;
            prev = n_rd;
        end
        check("stop_read_reached", reads, 2);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_strobes", {n_convst, n_cs, n_rd}, 3'b111);
        check("stop_busy", busy, 0);
        check("stop_wr_ptr", wr_ptr, 1);
        check("stop_done", done, 0);

        // Timeout: ADC never signals end of conversion
        adc_en = 1'b0;
        do_arm(1'b1);
        k = 0;
        while (n_convst && k < 100) begin @(negedge clk); k++; end
        check("to_convst_low", n_convst, 0);
        k = 0;
        while (!n_convst && k < 100) begin @(negedge clk); k++; end
        k = 0;
        while (!timeout && k < 400) begin @(negedge clk); k++; end
        check("to_latency", k, EOC_TIMEOUT);
        check("to_flag", timeout, 1);
        check("to_busy", busy, 0);
        check("to_strobes", {n_convst, n_cs, n_rd}, 3'b111);

        // Asynchronous reset in the middle of a READ
        adc_en = 1'b1;
        @(negedge clk);
        do_arm(1'b1);
        fv_n = 0;
        for (int i = 0; i < 1000 && fv_n < 1; i++) begin
            @(negedge clk);
            if (frame_valid) fv_n++;
        end
        k = 0;
        while (n_rd && k < 200) begin @(negedge clk); k++; end
        check("ar_in_read", n_rd, 0);
        check("ar_pre_wr_ptr", wr_ptr, 4);
        reset = 1'b1;
        #1;
        check("ar_strobes", {n_cs, n_rd}, 2'b11);
        check("ar_wr_ptr", wr_ptr, 0);
        check("ar_latest", latest, 0);
        check("ar_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/adc_scan_capture.md
# adc_scan_capture

Parametrised multi-channel capture engine for the array's parallel-output ADC. It drives the ADC's convert/chip-select/read handshake itself and scans NUM_CH channels per frame, paced by a programmable frame timer. Each sample is written interleaved into an internal capture RAM, with continuous ring or one-shot fill modes. The block exposes per-channel latest values, status flags and a 1-cycle-latency read port for readout logic.

## Interface
- DATA_W, 8, ADC sample width
- NUM_CH, 4, channels per frame; power of two, ≤ 2**CH_W
- CH_W, 3, width of ADC channel selector
- ADDR_W, 12, capture RAM address width; depth 2**ADDR_W words
- CONV_CYCLES, 2, n_convst low pulse length in clk cycles (≥1)
- RD_CYCLES, 3, n_cs/n_rd low length in clk cycles (≥1)
- SAMPLE_DIV, 1000, frame period in clk cycles (≥2)
- EOC_TIMEOUT, 255, max cycles waiting on n_eoc in any wait state

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- arm  in  1  start-capture strobe; ignored while busy
- stop  in  1  abort strobe; wins over arm
- one_shot  in  1  mode, sampled on accepted arm: 1 = stop when RAM full, 0 = ring
- chnl  out  CH_W  ADC channel select
- n_convst  out  1  active-low conversion start
- n_eoc  in  1  active-low end of conversion (asynchronous)
- n_cs  out  1  active-low ADC chip select
- n_rd  out  1  active-low ADC read
- adc_in  in  DATA_W  ADC data bus
- latest  out  NUM_CH*DATA_W  last sample per channel, ch0 in LSBs
- frame_valid  out  1  1-cycle pulse when a frame's last sample is written
- busy, done, overrun, timeout  out  1 each  status
- wr_ptr  out  ADDR_W  next RAM write address
- rd_addr  in  ADDR_W  readout address
- rd_data  out  DATA_W  RAM word at rd_addr, registered

## Operation
- Reset values: chnl=0, n_convst=n_cs=n_rd=1, latest=0, frame_valid=0, busy=done=overrun=timeout=0, wr_ptr=0, rd_data=0, state IDLE, frame timer 0.
- n_eoc passes a 2-flop synchroniser; FSM uses synchronised value (eoc_s).
- States: IDLE, SETUP, CONV, WAIT_EOC, READ, WRITE, WAIT_TICK.
- IDLE: accepted arm → clears wr_ptr, done, overrun, timeout, channel index, frame timer; latches one_shot; busy=1; → SETUP.
- SETUP: chnl = channel index; waits for eoc_s high (ADC idle), ≥1 cycle; → CONV.
- CONV: n_convst low exactly CONV_CYCLES cycles; → WAIT_EOC.
- WAIT_EOC: wait for eoc_s low; → READ.
- READ: n_cs=n_rd=0 exactly RD_CYCLES cycles; adc_in captured on last READ cycle's edge; strobes high the next cycle.
- WRITE (1 cycle): RAM[wr_ptr] ← sample; latest slot[ch] ← sample; wr_ptr+1, wrapping 2**ADDR_W-1 → 0. If ch < NUM_CH-1: ch+1 → SETUP. Else ch=0, frame_valid=1; if one_shot and wr_ptr wraps to 0: done=1, busy=0 → IDLE; else → WAIT_TICK.
- WAIT_TICK: on frame tick → SETUP.
- Frame timer: free-runs while busy, 0..SAMPLE_DIV-1; tick when at SAMPLE_DIV-1. Tick outside WAIT_TICK sets sticky overrun and is dropped; frame starts on the next tick.
- Timeout: counter reset on entering SETUP/WAIT_EOC; reaching EOC_TIMEOUT sets timeout=1, busy=0, strobes high → IDLE.
- stop (any busy state): next cycle → IDLE, strobes high, busy=0; done, wr_ptr and RAM untouched; partial frame stays in RAM.
- Read port independent of capture; same-address write/read returns old data.

## Timing
- Per-channel minimum: 1 SETUP + CONV_CYCLES + 2 sync + RD_CYCLES + 1 WRITE, plus ADC conversion time.
- First frame starts the cycle after arm (no tick wait).
- rd_data latency 1 cycle from rd_addr.
- frame_valid coincides with the last sample's RAM write; latest updated the same edge.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); RAM contents undefined.

## Test plan
- NUM_CH=4, ADDR_W=4, one_shot=1, ADC model returns 8'h10*frame+ch: arm → 4 frame_valid pulses, done=1, busy=0, wr_ptr=0, RAM[4f+c]=8'h10*f+c.
- one_shot=0, 5 frames → RAM[0..3]=8'h40..8'h43, RAM[4..15] from frames 1-3, busy stays 1, latest=32'h43424140.
- SAMPLE_DIV=10, frame length >10 cycles → overrun=1 after first frame, capture continues, no samples lost.
- n_eoc held high → timeout=1 exactly EOC_TIMEOUT cycles after WAIT_EOC entry; busy=0, n_convst=n_cs=n_rd=1.
- Check strobe widths: n_convst low exactly CONV_CYCLES, n_rd low exactly RD_CYCLES; stop during READ → strobes high next cycle, busy=0, wr_ptr unchanged.
- reset asserted during READ → n_cs=n_rd=1, wr_ptr=0, latest=0 without a clock edge.
